// File: rtl/disp_scan_keybuf_if.sv
// Bundles the keypad-entry inputs and the multiplexed display outputs of
// disp_scan_keybuf. The producer of keys (master) drives key_valid/key_code/clr
// and watches the display; the block itself (slave) does the reverse.
interface disp_scan_keybuf_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       clr;
  logic [1:0] sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       full;

  modport master (
    output key_valid, key_code, clr,
    input  sel, an, seg, full
  );

  modport slave (
    input  key_valid, key_code, clr,
    output sel, an, seg, full
  );
endinterface

// File: rtl/disp_scan_keybuf.sv
// Four-digit keypad entry buffer driving a multiplexed, active-low 7-segment
// display. Keys shift in at digit 0; older digits move toward digit 3. The
// scan runs free from a prescaler and blanks all anodes for GUARD cycles after
// each digit change to avoid ghosting.
module disp_scan_keybuf #(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned GUARD = 2
) (
  input logic               ck,
  input logic               rst_n,
  disp_scan_keybuf_if.slave bus
);

  localparam int unsigned   PW         = $clog2(DIV);
  localparam logic [PW-1:0] DIV_LAST   = PW'(DIV - 1);
  // Reset behaves like the cycle right after a digit change, so the guard
  // counter starts with the remaining blank cycles already loaded.
  localparam logic [PW-1:0] GUARD_INIT = (GUARD > 0) ? PW'(GUARD - 1) : '0;
  localparam logic [6:0]    BLANK      = 7'h7F;

  logic [PW-1:0]  pre_q;
  logic [PW-1:0]  guard_q;
  logic [1:0]     sel_q;
  logic [3:0]     an_q;
  logic [6:0]     seg_q;
  logic [6:0]     seg_next;
  logic [3:0][3:0] d_q;
  logic [3:0][3:0] d_next;
  logic [2:0]     cnt_q;
  logic [2:0]     cnt_next;
  logic           full_q;
  logic           tick;

  // Standard active-low hex patterns, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign tick = (pre_q == DIV_LAST);

  // Free-running scan: prescaler, digit index and anode guard blanking.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values of the others regardless of statement order.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      sel_q   <= 2'b00;
      guard_q <= GUARD_INIT;
      an_q    <= 4'b1111;
    end else begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
      if (tick) sel_q <= sel_q + 2'd1;
      if (tick && (GUARD != 0)) begin
        an_q    <= 4'b1111;
        guard_q <= GUARD_INIT;
      end else if (guard_q != '0) begin
        an_q    <= 4'b1111;
        guard_q <= guard_q - 1'b1;
      end else begin
        an_q    <= ~(4'b0001 << sel_q);
      end
    end
  end

  // Next buffer contents: clear beats an incoming key, keys shift in at d0.
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    d_next   = d_q;
    cnt_next = cnt_q;
    if (bus.clr) begin
      d_next   = '0;
      cnt_next = 3'd0;
    end else if (bus.key_valid) begin
      d_next = {d_q[2:0], bus.key_code};
      if (cnt_q != 3'd4) cnt_next = cnt_q + 3'd1;
    end
  end

  // Digit buffer, count and the full flag (taken from the next count so the
  // flag never lags the count).
  // NOTE: the digit storage is reset, unlike an ordinary register array,
  // because a reset must leave a blank display and drop any pending entry.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      d_q    <= '0;
      cnt_q  <= 3'd0;
      full_q <= 1'b0;
    end else begin
      d_q    <= d_next;
      cnt_q  <= cnt_next;
      full_q <= (cnt_next == 3'd4);
    end
  end

  // Segment pattern for the digit currently scanned; unused digits stay blank.
  always_comb begin
    seg_next = BLANK;
    if ({1'b0, sel_q} < cnt_q) seg_next = hex7(d_q[sel_q]);
  end

  // Register the segment pattern one cycle behind sel/buffer changes.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) seg_q <= BLANK;
    else        seg_q <= seg_next;
  end

  assign bus.sel  = sel_q;
  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.full = full_q;

endmodule

// File: tb/tb_disp_scan_keybuf.sv
// Self-checking bench for disp_scan_keybuf. Two instances (GUARD=1 and
// GUARD=0, both DIV=4) share clock, reset and key stimulus. A reference model
// tracks the scan position arithmetically from the number of clock edges
// since reset release and holds the entered digits as a newest-first queue.
module tb_disp_scan_keybuf;

  localparam int DIV = 4;

  logic ck = 1'b0;
  logic rst_n;
  logic kv;
  logic [3:0] kc;
  logic clr_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: edges since reset release, digits newest-first.
  int n;
  int keys[$];

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  disp_scan_keybuf_if bus1 ();
  disp_scan_keybuf_if bus0 ();

  assign bus1.key_valid = kv;
  assign bus1.key_code  = kc;
  assign bus1.clr       = clr_i;
  assign bus0.key_valid = kv;
  assign bus0.key_code  = kc;
  assign bus0.clr       = clr_i;

  disp_scan_keybuf #(.DIV(DIV), .GUARD(1)) dut_g1 (.ck(ck), .rst_n(rst_n), .bus(bus1));
  disp_scan_keybuf #(.DIV(DIV), .GUARD(0)) dut_g0 (.ck(ck), .rst_n(rst_n), .bus(bus0));

  always #5 ck = ~ck;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  function automatic int sel_at(input int e);
    return (e / DIV) % 4;
  endfunction

  // Anodes: blank for g cycles after every digit change (and after reset);
  // with g=0 they simply show the previous cycle's digit.
  function automatic logic [3:0] an_model(input int g, input int e);
    logic [3:0] one;
    one = 4'b0001;
    if (g == 0) begin
      if (e == 0) return 4'b1111;
      return ~(one << sel_at(e - 1));
    end
    if ((e % DIV) < g) return 4'b1111;
    return ~(one << sel_at(e));
  endfunction

  task automatic check_all(input int old_n, input int old_keys[$]);
    int sp;
    logic [6:0] exp_seg;
    logic exp_full;
    sp       = sel_at(old_n);
    exp_seg  = (sp < old_keys.size()) ? hex_tab[old_keys[sp]] : 7'h7F;
    exp_full = (keys.size() == 4);
    check("sel_g1",  32'(bus1.sel),  32'(sel_at(n)));
    check("sel_g0",  32'(bus0.sel),  32'(sel_at(n)));
    check("an_g1",   32'(bus1.an),   32'(an_model(1, n)));
    check("an_g0",   32'(bus0.an),   32'(an_model(0, n)));
    check("seg_g1",  32'(bus1.seg),  32'(exp_seg));
    check("seg_g0",  32'(bus0.seg),  32'(exp_seg));
    check("full_g1", 32'(bus1.full), 32'(exp_full));
    check("full_g0", 32'(bus0.full), 32'(exp_full));
  endtask

  // One clock: update the model with the inputs present at the edge, then check.
  task automatic step();
    int old_n;
    int old_keys[$];
    old_n    = n;
    old_keys = keys;
    @(posedge ck);
    if (clr_i) keys.delete();
    else if (kv) begin
      keys.push_front(int'(kc));
      if (keys.size() > 4) void'(keys.pop_back());
    end
    n++;
    #1;
    check_all(old_n, old_keys);
  endtask

  task automatic key(input int k);
    kv = 1'b1;
    kc = 4'(k);
    step();
    kv = 1'b0;
    step();
  endtask

  task automatic clear();
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
  endtask

  // Advance until seg shows digit i of GUARD=1 instance, then compare to a constant.
  task automatic expect_digit(input int i, input logic [6:0] pattern, input string tag);
    step();
    while (sel_at(n - 1) != i) step();
    check(tag, 32'(bus1.seg), 32'(pattern));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sel"},  32'(bus1.sel),  32'd0);
    check({tag, "_an"},   32'(bus1.an),   32'hF);
    check({tag, "_seg"},  32'(bus1.seg),  32'h7F);
    check({tag, "_full"}, 32'(bus1.full), 32'd0);
    check({tag, "_an0"},  32'(bus0.an),   32'hF);
    check({tag, "_seg0"}, 32'(bus0.seg),  32'h7F);
  endtask

  initial begin
    rst_n = 1'b0;
    kv    = 1'b0;
    kc    = 4'h0;
    clr_i = 1'b0;
    n     = 0;
    repeat (2) @(posedge ck);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;

    // Idle scan with an empty buffer.
    repeat (40) step();

    // Three keys, then watch each digit.
    key(1); key(2); key(3);
    check("full_after3", 32'(bus1.full), 32'd0);
    expect_digit(0, 7'b0110000, "digit0_is_3");
    expect_digit(1, 7'b0100100, "digit1_is_2");
    expect_digit(2, 7'b1111001, "digit2_is_1");
    expect_digit(3, 7'h7F,      "digit3_blank");

    // Five keys overflow the buffer; the oldest is dropped.
    clear();
    key(1); key(2); key(3);
    kv = 1'b1; kc = 4'd4; step(); kv = 1'b0;
    check("full_after4", 32'(bus1.full), 32'd1);
    step();
    key(5);
    expect_digit(0, 7'b0010010, "ovf_digit0_is_5");
    expect_digit(3, 7'b0100100, "ovf_digit3_is_2");

    // Clear collides with a key: clear wins, key is lost.
    clr_i = 1'b1; kv = 1'b1; kc = 4'd8; step();
    clr_i = 1'b0; kv = 1'b0;
    check("clr_full", 32'(bus1.full), 32'd0);
    repeat (16) step();

    // Random entry traffic.
    for (int i = 0; i < 300; i++) begin
      kv    = ($urandom_range(0, 3) == 0);
      kc    = 4'($urandom_range(0, 15));
      clr_i = ($urandom_range(0, 31) == 0);
      step();
    end
    kv = 1'b0; clr_i = 1'b0;

    // Asynchronous reset mid-scan with two digits held and sel=2.
    clear();
    key(7); key(10);
    while (sel_at(n) != 2) step();
    check("pre_rst_sel", 32'(bus1.sel), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(posedge ck);
    #1;
    check_reset_values("held_rst");
    rst_n = 1'b1;
    n = 0;
    keys.delete();

    // Scan and entry resume cleanly after reset.
    repeat (12) step();
    for (int i = 0; i < 120; i++) begin
      kv    = ($urandom_range(0, 2) == 0);
      kc    = 4'($urandom_range(0, 15));
      clr_i = ($urandom_range(0, 40) == 0);
      step();
    end
    kv = 1'b0; clr_i = 1'b0;
    repeat (8) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_scan_keybuf.md
DISP_SCAN_KEYBUF -- requirements
Module: disp_scan_keybuf

Parameters
REQ-001 The block SHALL have parameter DIV, default 50000, giving clock cycles per digit slot; legal range 4 to 2^20.
REQ-002 The block SHALL have parameter GUARD, default 2, giving anode-off cycles after each digit change; legal range 0 to DIV-1.

Interface
REQ-003 The block SHALL have port ck, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port key_valid, input, 1 bit: one-cycle strobe indicating key_code holds a new key.
REQ-006 The block SHALL have port key_code, input, 4 bits: hex key value 0-F from the keypad decoder.
REQ-007 The block SHALL have port clr, input, 1 bit: synchronous clear of the digit buffer.
REQ-008 The block SHALL have port sel, output, 2 bits: index of the currently scanned digit.
REQ-009 The block SHALL have port an, output, 4 bits: digit enables, active-low, an[i] drives digit i.
REQ-010 The block SHALL have port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-011 The block SHALL have port full, output, 1 bit: high when 4 digits are held.

Function
REQ-012 The prescaler SHALL count 0..DIV-1, assert an internal tick for one cycle when it equals DIV-1, and wrap to 0.
REQ-013 sel SHALL increment by 1 on the clock edge ending each tick cycle and wrap from 3 to 0; otherwise it holds.
REQ-014 The block SHALL hold digits d0..d3, each 4 bits, plus a count cnt ranging 0..4.
REQ-015 When key_valid=1 and clr=0, the block SHALL shift the buffer: d3<=d2, d2<=d1, d1<=d0, d0<=key_code.
REQ-016 On an accepted key, cnt SHALL increment and saturate at 4; when cnt=4, the key SHALL still shift in and the old d3 SHALL be discarded.
REQ-017 When clr=1, the block SHALL set d0..d3 to 0 and cnt to 0 on the next edge; clr SHALL win over a simultaneous key_valid, and that key SHALL be dropped.
REQ-018 full SHALL be a registered output equal to (cnt==4).
REQ-019 Digit i SHALL be lit only if i<cnt; otherwise its seg value SHALL be 7'h7F (blank).
REQ-020 seg SHALL be registered: one cycle after any change of sel, buffer or cnt, seg SHALL show the hex decode of d[sel], or blank per REQ-019.
REQ-021 The hex decode SHALL use standard patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-022 an SHALL be registered; for GUARD cycles starting the cycle sel changes, an SHALL be 4'b1111, after which an SHALL equal ~(4'b0001<<sel).
REQ-023 With GUARD=0, an SHALL follow sel with one cycle of latency and no blank interval.
REQ-024 The scan (prescaler, sel, an guard) SHALL be unaffected by key_valid and clr.

Reset
REQ-025 While rst_n=0, asynchronously, the prescaler SHALL be 0, sel 2'b00, d0..d3 4'h0, cnt 0, full 0, an 4'b1111 and seg 7'h7F.
REQ-026 After rst_n deasserts, the first tick SHALL occur DIV cycles later, and the guard interval SHALL be armed as if sel had just changed.
REQ-027 Reset asserted mid-scan or mid-entry SHALL abort immediately to the REQ-025 values, and no partial key SHALL be retained.

Verification (DIV=4, GUARD=1 unless stated)
REQ-028 Reset then idle 40 cycles -> sel steps 0,1,2,3,0 every 4 cycles; an is 1111 for 1 cycle after each step, then 1110, 1101, 1011, 0111; seg stays 7F.
REQ-029 Keys 1,2,3 then scan -> cnt=3, full=0; digit0 seg=0110000, digit1=0100100, digit2=1111001, digit3 blank 7F.
REQ-030 Keys 1,2,3,4,5 -> full=1 after the 4th key; buffer d3..d0=2,3,4,5; digit0 seg=0010010.
REQ-031 clr and key_valid with key_code=8 in the same cycle -> cnt=0, all seg 7F, key 8 absent.
REQ-032 rst_n pulsed low mid-scan with sel=2 and cnt=2 -> sel=0, an=1111, seg=7F, full=0 immediately, without waiting for a clock edge.
REQ-033 GUARD=0 run -> an never 1111 after reset release; an changes exactly one cycle after sel.
